// File: rtl/id_rtype_decode_queue_if.sv
// Issue-side bundle for the R-format decode queue: push lanes, issue slots, pop and flush.
// out_op carries the 6-bit encoding of id_rtype_decode_pkg::op_e.
interface id_rtype_decode_queue_if #(
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2
);
   localparam int IN_CW  = $clog2(FETCH_WIDTH + 1);
   localparam int OUT_CW = $clog2(ISSUE_WIDTH + 1);

   logic                              flush;
   logic                              in_valid;
   logic [IN_CW-1:0]                  in_count;
   logic [FETCH_WIDTH-1:0][31:0]      in_inst;
   logic [FETCH_WIDTH-1:0][31:0]      in_pc;
   logic                              in_ready;

   logic [ISSUE_WIDTH-1:0]            out_valid;
   logic [ISSUE_WIDTH-1:0][5:0]       out_op;
   logic [ISSUE_WIDTH-1:0][4:0]       out_raddr1;
   logic [ISSUE_WIDTH-1:0][4:0]       out_raddr2;
   logic [ISSUE_WIDTH-1:0][4:0]       out_waddr;
   logic [ISSUE_WIDTH-1:0]            out_we;
   logic [ISSUE_WIDTH-1:0]            out_is_rtype;
   logic [ISSUE_WIDTH-1:0][31:0]      out_inst;
   logic [ISSUE_WIDTH-1:0][31:0]      out_pc;
   logic [OUT_CW-1:0]                 pop_count;

   modport master (
      output flush, in_valid, in_count, in_inst, in_pc, pop_count,
      input  in_ready, out_valid, out_op, out_raddr1, out_raddr2, out_waddr,
             out_we, out_is_rtype, out_inst, out_pc
   );

   modport slave (
      input  flush, in_valid, in_count, in_inst, in_pc, pop_count,
      output in_ready, out_valid, out_op, out_raddr1, out_raddr2, out_waddr,
             out_we, out_is_rtype, out_inst, out_pc
   );
endinterface

// File: rtl/id_rtype_decode_queue.sv
// Circular IF->ID buffer that pre-decodes SPECIAL/SPECIAL2/COP0 instructions at enqueue.
// Optional SPECIAL2 decode is enabled by defining CPU_DECODE_SPECIAL2_EN.
package id_rtype_decode_pkg;
   typedef enum logic [5:0] {
      OP_INVALID, OP_NOP,
      OP_AND, OP_OR, OP_XOR, OP_NOR,
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MOVN, OP_MOVZ,
      OP_JR, OP_JALR,
      OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU,
      OP_MULT, OP_MULTU,
      OP_MFC0, OP_MTC0, OP_ERET,
      OP_CLZ, OP_CLO, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL
   } op_e;

   typedef struct packed {
      op_e         op;
      logic [4:0]  raddr1;
      logic [4:0]  raddr2;
      logic [4:0]  waddr;
      logic        we;
      logic        is_rtype;
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
   localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OPC_COP0     = 6'b010000;
endpackage

module id_rtype_decode_queue
   import id_rtype_decode_pkg::*;
#(
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH       = 8
) (
   input logic                clk,
   input logic                rst_n,
   id_rtype_decode_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);

   function automatic entry_t decode(input logic [31:0] inst, input logic [31:0] pc);
      entry_t     e;
      logic [5:0] opc;
      logic [5:0] funct;
      logic [4:0] rs;
      logic [4:0] rt;
      opc   = inst[31:26];
      funct = inst[5:0];
      rs    = inst[25:21];
      rt    = inst[20:16];
      e.inst     = inst;
      e.pc       = pc;
      e.op       = OP_INVALID;
      e.raddr1   = rs;
      e.raddr2   = rt;
      e.waddr    = inst[15:11];
      e.we       = 1'b1;
      e.is_rtype = (opc == OPC_SPECIAL) || (opc == OPC_SPECIAL2) || (opc == OPC_COP0);

      if (inst == 32'h0) begin
         e.op     = OP_NOP;
         e.raddr1 = '0;
         e.raddr2 = '0;
         e.waddr  = '0;
         e.we     = 1'b0;
      end else if (opc == OPC_SPECIAL) begin
         case (funct)
            6'h00: e.op = OP_SLL;   6'h02: e.op = OP_SRL;   6'h03: e.op = OP_SRA;
            6'h04: e.op = OP_SLLV;  6'h06: e.op = OP_SRLV;  6'h07: e.op = OP_SRAV;
            6'h08: e.op = OP_JR;    6'h09: e.op = OP_JALR;
            6'h0A: e.op = OP_MOVZ;  6'h0B: e.op = OP_MOVN;
            6'h10: e.op = OP_MFHI;  6'h11: e.op = OP_MTHI;
            6'h12: e.op = OP_MFLO;  6'h13: e.op = OP_MTLO;
            6'h18: e.op = OP_MULT;  6'h19: e.op = OP_MULTU;
            6'h20: e.op = OP_ADD;   6'h21: e.op = OP_ADDU;
            6'h22: e.op = OP_SUB;   6'h23: e.op = OP_SUBU;
            6'h24: e.op = OP_AND;   6'h25: e.op = OP_OR;
            6'h26: e.op = OP_XOR;   6'h27: e.op = OP_NOR;
            6'h2A: e.op = OP_SLT;   6'h2B: e.op = OP_SLTU;
            default: e.op = OP_INVALID;
         endcase
      end else if (opc == OPC_SPECIAL2) begin
`ifdef CPU_DECODE_SPECIAL2_EN
         case (funct)
            6'h20: begin e.op = OP_CLZ; e.raddr2 = '0; end
            6'h21: begin e.op = OP_CLO; e.raddr2 = '0; end
            6'h00: e.op = OP_MADD;
            6'h01: e.op = OP_MADDU;
            6'h04: e.op = OP_MSUB;
            6'h05: e.op = OP_MSUBU;
            6'h02: e.op = OP_MUL;
            default: e.op = OP_INVALID;
         endcase
`else
         e.op = OP_INVALID;
`endif
      end else if (opc == OPC_COP0) begin
         case (rs)
            5'b00000: begin
               e.op     = OP_MFC0;
               e.waddr  = rt;
               e.raddr1 = '0;
               e.raddr2 = '0;
            end
            5'b00100: begin
               e.op     = OP_MTC0;
               e.raddr1 = '0;
               e.we     = 1'b0;
            end
            5'b10000: begin
               e.op     = (funct == 6'b011000) ? OP_ERET : OP_INVALID;
               e.raddr1 = '0;
               e.we     = 1'b0;
            end
            default: e.op = OP_INVALID;
         endcase
      end

      // HI/LO, jump-register and multiply-accumulate ops consume registers but never write rd.
      if (e.op inside {OP_MTHI, OP_MTLO, OP_JR, OP_MULT, OP_MULTU,
                       OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_INVALID}) begin
         e.we    = 1'b0;
         e.waddr = '0;
      end
      return e;
   endfunction

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [OW-1:0] occ;
   logic          in_ready;
   int            push_n;
   int            pop_n;
   entry_t        dec [FETCH_WIDTH];
   entry_t        mem [DEPTH];

   assign in_ready     = (DEPTH - int'(occ)) >= FETCH_WIDTH;
   assign bus.in_ready = in_ready;

   always_comb begin
      // NOTE: every comb output gets a default before any condition, so no path can infer a latch.
      push_n = 0;
      pop_n  = 0;
      if (bus.in_valid && in_ready && !bus.flush)
         push_n = (int'(bus.in_count) > FETCH_WIDTH) ? FETCH_WIDTH : int'(bus.in_count);
      if (!bus.flush)
         pop_n = (int'(bus.pop_count) > int'(occ)) ? int'(occ) : int'(bus.pop_count);
   end

   always_comb begin
      for (int i = 0; i < FETCH_WIDTH; i++) dec[i] = decode(bus.in_inst[i], bus.in_pc[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else if (bus.flush) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         head <= head + PW'(pop_n);
         tail <= tail + PW'(push_n);
         occ  <= OW'(int'(occ) + push_n - pop_n);
      end
   end

   // NOTE: entry storage has no reset; occupancy alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (i < push_n) mem[tail + PW'(i)] <= dec[i];
      end
   end

   always_comb begin
      entry_t e;
      bus.out_valid    = '0;
      bus.out_op       = '0;
      bus.out_raddr1   = '0;
      bus.out_raddr2   = '0;
      bus.out_waddr    = '0;
      bus.out_we       = '0;
      bus.out_is_rtype = '0;
      bus.out_inst     = '0;
      bus.out_pc       = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         e = mem[head + PW'(k)];
         bus.out_valid[k]    = int'(occ) > k;
         bus.out_op[k]       = e.op;
         bus.out_raddr1[k]   = e.raddr1;
         bus.out_raddr2[k]   = e.raddr2;
         bus.out_waddr[k]    = e.waddr;
         bus.out_we[k]       = e.we;
         bus.out_is_rtype[k] = e.is_rtype;
         bus.out_inst[k]     = e.inst;
         bus.out_pc[k]       = e.pc;
      end
   end
endmodule

// File: tb/tb_id_rtype_decode_queue.sv
// Bench for id_rtype_decode_queue: decode vector table plus scoreboarded queue sequences.
`timescale 1ns/1ps
module tb_id_rtype_decode_queue;
   import id_rtype_decode_pkg::*;

   localparam int FW    = 2;
   localparam int IW    = 2;
   localparam int DEPTH = 8;
   localparam int ICW   = $clog2(FW + 1);
   localparam int OCW   = $clog2(IW + 1);

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      op_e         op;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  w;
      logic        we;
      logic        is_r;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   gen_id   = 0;
   vec_t pend[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   id_rtype_decode_queue_if #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) bus ();
   id_rtype_decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] inst, input op_e op, input int r1, input int r2,
                               input int w, input bit we, input bit is_r);
      vec_t v;
      v.inst = inst; v.pc = 32'h400 + 32'(gen_id * 4);
      v.op = op; v.r1 = 5'(r1); v.r2 = 5'(r2); v.w = 5'(w); v.we = we; v.is_r = is_r;
      return v;
   endfunction

   // ADDU entries with index-dependent fields so order errors are visible.
   task automatic gen(input int n);
      for (int i = 0; i < n; i++) begin
         logic [4:0] rs, rt, rd;
         rs = 5'(gen_id); rt = 5'(gen_id + 7); rd = 5'(gen_id + 13);
         pend.push_back(mk({6'h00, rs, rt, rd, 5'h00, 6'h21}, OP_ADDU, rs, rt, rd, 1, 1));
         gen_id++;
      end
   endtask

   // Compares visible state against the model, drives one cycle, then updates the model.
   task automatic step(input int n_push, input int pop_req, input bit do_flush);
      int               occ, np, pops;
      bit               rdy, fire;
      logic [IW-1:0]    ev;
      occ = sb.size();
      rdy = (DEPTH - occ) >= FW;
      for (int k = 0; k < IW; k++) ev[k] = occ > k;
      check("in_ready", 128'(bus.in_ready), 128'(rdy));
      check("out_valid", 128'(bus.out_valid), 128'(ev));
      for (int k = 0; k < IW; k++) begin
         if (k < occ) begin
            check($sformatf("slot%0d decode", k),
                  128'({bus.out_op[k], bus.out_raddr1[k], bus.out_raddr2[k], bus.out_waddr[k],
                        bus.out_we[k], bus.out_is_rtype[k]}),
                  128'({sb[k].op, sb[k].r1, sb[k].r2, sb[k].w, sb[k].we, sb[k].is_r}));
            check($sformatf("slot%0d raw", k),
                  128'({bus.out_inst[k], bus.out_pc[k]}), 128'({sb[k].inst, sb[k].pc}));
         end
      end
      np = n_push;
      if (np > FW) np = FW;
      if (np > pend.size()) np = pend.size();
      bus.in_valid  = (n_push > 0);
      bus.in_count  = ICW'(np);
      bus.pop_count = OCW'(pop_req);
      bus.flush     = do_flush;
      for (int l = 0; l < FW; l++) begin
         bus.in_inst[l] = (l < np) ? pend[l].inst : 32'h0;
         bus.in_pc[l]   = (l < np) ? pend[l].pc   : 32'h0;
      end
      fire = (n_push > 0) && rdy;
      @(posedge clk);
      if (do_flush) begin
         sb.delete();
         if (fire) for (int l = 0; l < np; l++) void'(pend.pop_front());
      end else begin
         pops = (pop_req > occ) ? occ : pop_req;
         for (int p = 0; p < pops; p++) void'(sb.pop_front());
         if (fire) for (int l = 0; l < np; l++) sb.push_back(pend.pop_front());
      end
      #1;
      bus.in_valid  = 1'b0;
      bus.in_count  = '0;
      bus.pop_count = '0;
      bus.flush     = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && sb.size() > 0; c++) step(0, 2, 0);
      check("drain finished", 128'(sb.size()), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_count = '0; bus.pop_count = '0; bus.flush = 1'b0;
      bus.in_inst = '0; bus.in_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 128'(bus.out_valid), 128'(0));
      check("reset in_ready", 128'(bus.in_ready), 128'(1));
      rst_n = 1'b1;
      step(0, 0, 0);

      // Decode table; 0x70221020 has funct 100000, i.e. CLZ r2,r1.
      pend.push_back(mk(32'h00430820, OP_ADD, 2, 3, 1, 1, 1));       gen_id++;
      pend.push_back(mk(32'h00000000, OP_NOP, 0, 0, 0, 0, 1));       gen_id++;
      pend.push_back(mk(32'h40016000, OP_MFC0, 0, 0, 1, 1, 1));      gen_id++;
      pend.push_back(mk(32'h40816000, OP_MTC0, 0, 1, 12, 0, 1));     gen_id++;
      pend.push_back(mk(32'h42000018, OP_ERET, 0, 0, 0, 0, 1));      gen_id++;
      pend.push_back(mk(32'h03E00008, OP_JR, 31, 0, 0, 0, 1));       gen_id++;
      pend.push_back(mk(32'h00850018, OP_MULT, 4, 5, 0, 0, 1));      gen_id++;
      pend.push_back(mk(32'h00E83023, OP_SUBU, 7, 8, 6, 1, 1));      gen_id++;
      pend.push_back(mk(32'h00430801, OP_INVALID, 2, 3, 0, 0, 1));   gen_id++;
      pend.push_back(mk(32'h20220005, OP_INVALID, 1, 2, 0, 0, 0));   gen_id++;
      pend.push_back(mk(32'h42000001, OP_INVALID, 0, 0, 0, 0, 1));   gen_id++;
      pend.push_back(mk(32'h00020900, OP_SLL, 0, 2, 1, 1, 1));       gen_id++;
`ifdef CPU_DECODE_SPECIAL2_EN
      pend.push_back(mk(32'h70221020, OP_CLZ, 1, 0, 2, 1, 1));       gen_id++;
      pend.push_back(mk(32'h70221002, OP_MUL, 1, 2, 2, 1, 1));       gen_id++;
      pend.push_back(mk(32'h70220000, OP_MADD, 1, 2, 0, 0, 1));      gen_id++;
`else
      pend.push_back(mk(32'h70221020, OP_INVALID, 1, 2, 0, 0, 1));   gen_id++;
      pend.push_back(mk(32'h70221002, OP_INVALID, 1, 2, 0, 0, 1));   gen_id++;
      pend.push_back(mk(32'h70220000, OP_INVALID, 1, 2, 0, 0, 1));   gen_id++;
`endif
      for (int c = 0; c < 40 && (pend.size() > 0 || sb.size() > 0); c++) step(2, 2, 0);
      check("table consumed", 128'(pend.size() + sb.size()), 128'(0));

      // Fill to occupancy 7: in_ready must drop, then recover after a pop of 2.
      gen(9);
      step(1, 0, 0);
      repeat (3) step(2, 0, 0);
      check("ready low at occupancy 7", 128'(bus.in_ready), 128'(0));
      step(2, 0, 0);
      step(0, 2, 0);
      check("ready back after pop", 128'(bus.in_ready), 128'(1));
      for (int c = 0; c < 20 && pend.size() > 0; c++) step(2, 2, 0);
      drain();

      // Wrap-around with mixed push/pop traffic.
      gen(20);
      for (int c = 0; c < 200 && pend.size() > 0; c++) step(2, $urandom_range(0, 2), 0);
      check("wrap all pushed", 128'(pend.size()), 128'(0));
      drain();

      // Simultaneous push/pop at occupancy 4, then pop clamp at occupancy 1 and 0.
      gen(8);
      step(2, 0, 0);
      step(2, 0, 0);
      step(2, 2, 0);
      check("occupancy held at 4", 128'(sb.size()), 128'(4));
      step(0, 2, 0);
      step(0, 1, 0);
      step(0, 2, 0);
      step(0, 2, 0);
      check("empty after clamp", 128'(bus.out_valid), 128'(0));
      step(2, 0, 0);
      drain();

      // Flush with a same-cycle push and pop: everything is discarded.
      gen(6);
      step(2, 0, 0);
      step(2, 0, 0);
      step(2, 1, 1);
      check("flush empties", 128'(bus.out_valid), 128'(0));
      gen(2);
      step(2, 0, 0);
      drain();

      // Asynchronous reset mid-traffic empties the queue before the next edge.
      gen(4);
      step(2, 0, 0);
      step(2, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset out_valid", 128'(bus.out_valid), 128'(0));
      check("async reset in_ready", 128'(bus.in_ready), 128'(1));
      sb.delete();
      pend.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
